// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants, state type and address helpers for the L1 miss-fill
// controller.
//   ADDR_W / DATA_W   : byte-address and word widths
//   WORDS_PER_BLOCK   : words per cache block (power of two, >= 2)
//   OFFSET_W / WSEL_W : byte-offset width and word-select width in a block
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int ADDR_W          = 16;
   localparam int DATA_W          = 16;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK * 2);
   localparam int WSEL_W          = $clog2(WORDS_PER_BLOCK);
   // issue_cnt must reach WORDS_PER_BLOCK itself, so it needs one extra bit
   localparam int ICNT_W          = WSEL_W + 1;

   localparam logic [ICNT_W-1:0] ISSUE_LIMIT = ICNT_W'(WORDS_PER_BLOCK);
   localparam logic [WSEL_W-1:0] LAST_WORD   = WSEL_W'(WORDS_PER_BLOCK - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Align a byte address to the start of its block.
   function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

   // Byte address of word wsel inside the block at base. Built by
   // concatenation so the address can never carry out of the block.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [WSEL_W-1:0] wsel);
      return {base[ADDR_W-1:OFFSET_W], wsel, 1'b0};
   endfunction

endpackage

// File: rtl/cache_fill_fsm_checker.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_checker
// Protocol checker for the fill controller: main memory must not return a
// word while no read is outstanding.
//   clk, rst_n        : clock and synchronous active-low reset
//   in_fill           : controller is in FILL
//   memory_data_valid : main memory returns a word this cycle
//   issue_cnt         : reads issued so far in this fill
//   ret_cnt           : words returned so far in this fill
// -----------------------------------------------------------------------------
module cache_fill_fsm_checker
   import cache_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   input logic              in_fill,
   input logic              memory_data_valid,
   input logic [ICNT_W-1:0] issue_cnt,
   input logic [WSEL_W-1:0] ret_cnt
);

   a_no_unrequested_return : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(in_fill && memory_data_valid && (issue_cnt == {1'b0, ret_cnt}))
   );

endmodule

// File: rtl/fill_word_counter.sv
// -----------------------------------------------------------------------------
// fill_word_counter
// Clearable, enabled, saturating up-counter used for the issue and return
// word counters of the fill controller.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear (wins over en)
//   en    : count one event this cycle
//   count : current count, saturates at MAX_COUNT
// -----------------------------------------------------------------------------
module fill_word_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_r;

   // Count register: reset and clear to zero, otherwise step up to MAX_VAL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && (count_r != MAX_VAL)) begin
         count_r <= count_r + WIDTH'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// L1 miss-fill controller. On a miss it streams the aligned block from main
// memory (one read per cycle), writes each returned word into the cache data
// array, writes the tag with the last word and stalls the pipeline meanwhile.
//   clk               : system clock
//   rst_n             : synchronous active-low reset
//   miss_detected     : cache miss this cycle (sampled only in IDLE)
//   miss_address      : byte address that missed
//   memory_data_valid : main memory returns a word (in issue order)
//   memory_data       : returned word
//   fsm_busy          : stall request to the hazard unit
//   mem_en            : read request to main memory
//   memory_address    : address of the read issued this cycle
//   write_data_array  : write memory_data into the data array
//   write_word_sel    : word index within the block being written
//   write_data        : data to write (memory_data)
//   write_tag_array   : write tag/valid for the latched block
//   fill_done         : one-cycle pulse with the last word write
// -----------------------------------------------------------------------------
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data,
   output logic              fsm_busy,
   output logic              mem_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [WSEL_W-1:0] write_word_sel,
   output logic [DATA_W-1:0] write_data,
   output logic              write_tag_array,
   output logic              fill_done
);

   fill_state_e       state_r;
   logic [ADDR_W-1:0] base_r;
   logic [ICNT_W-1:0] issue_cnt_s;
   logic [WSEL_W-1:0] ret_cnt_s;

   logic in_fill_s;
   logic issue_s;
   logic ret_s;
   logic last_s;
   logic cnt_clr_s;

   assign in_fill_s = (state_r == FILL);
   assign issue_s   = in_fill_s && (issue_cnt_s < ISSUE_LIMIT);
   assign ret_s     = in_fill_s && memory_data_valid;
   assign last_s    = ret_s && (ret_cnt_s == LAST_WORD);
   // Counters sit at zero in IDLE, so a new fill always starts from word 0.
   assign cnt_clr_s = !in_fill_s || last_s;

   fill_word_counter #(
      .WIDTH     (ICNT_W),
      .MAX_COUNT (WORDS_PER_BLOCK)
   ) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .en    (issue_s),
      .count (issue_cnt_s)
   );

   fill_word_counter #(
      .WIDTH     (WSEL_W),
      .MAX_COUNT (WORDS_PER_BLOCK - 1)
   ) u_ret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .en    (ret_s),
      .count (ret_cnt_s)
   );

   // State and block-base register: latch the block on a miss, return to
   // IDLE with the last returned word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         base_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_detected) begin
                  state_r <= FILL;
                  base_r  <= block_base(miss_address);
               end else begin
                  state_r <= IDLE;
                  base_r  <= base_r;
               end
            end
            FILL: begin
               if (last_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= FILL;
               end
               base_r <= base_r;
            end
            default: begin
               state_r <= IDLE;
               base_r  <= '0;
            end
         endcase
      end
   end

   // Output decode from state, counters and the current-cycle inputs.
   always_comb begin
      fsm_busy         = 1'b0;
      mem_en           = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_word_sel   = '0;
      write_data       = '0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;
      case (state_r)
         IDLE: begin
            // Stall already in the miss cycle.
            fsm_busy = miss_detected;
         end
         FILL: begin
            fsm_busy = 1'b1;
            if (issue_s) begin
               mem_en         = 1'b1;
               memory_address = word_addr(base_r, issue_cnt_s[WSEL_W-1:0]);
            end else begin
               mem_en         = 1'b0;
               memory_address = base_r;
            end
            if (ret_s) begin
               write_data_array = 1'b1;
               write_word_sel   = ret_cnt_s;
               write_data       = memory_data;
            end else begin
               write_data_array = 1'b0;
            end
            if (last_s) begin
               write_tag_array = 1'b1;
               fill_done       = 1'b1;
            end else begin
               write_tag_array = 1'b0;
               fill_done       = 1'b0;
            end
         end
         default: begin
            fsm_busy = 1'b0;
         end
      endcase
   end

   cache_fill_fsm_checker u_checker (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_fill           (in_fill_s),
      .memory_data_valid (memory_data_valid),
      .issue_cnt         (issue_cnt_s),
      .ret_cnt           (ret_cnt_s)
   );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
// Directed bench for cache_fill_fsm. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the following falling edge. "Cycle c" of a
// scenario is the clock period whose inputs were applied by the c-th step.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  write_word_sel;
   logic [15:0] write_data;
   logic        write_tag_array;
   logic        fill_done;

   int checks;
   int errors;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_en            (mem_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .write_word_sel    (write_word_sel),
      .write_data        (write_data),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs, then wait for the sampling edge.
   task automatic step(input logic r, input logic m, input logic [15:0] a,
                       input logic v, input logic [15:0] d);
      @(posedge clk);
      #1;
      rst_n             = r;
      miss_detected     = m;
      miss_address      = a;
      memory_data_valid = v;
      memory_data       = d;
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
      checks++; if (fsm_busy !== 1'b0) begin errors++; $display("FAIL reset fsm_busy got %b exp 0", fsm_busy); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset mem_en got %b exp 0", mem_en); end
      checks++; if (memory_address !== 16'h0000) begin errors++; $display("FAIL reset memory_address got %h exp 0000", memory_address); end
      checks++; if (write_data_array !== 1'b0) begin errors++; $display("FAIL reset write_data_array got %b exp 0", write_data_array); end
      checks++; if (write_word_sel !== 3'd0) begin errors++; $display("FAIL reset write_word_sel got %0d exp 0", write_word_sel); end
      checks++; if (write_data !== 16'h0000) begin errors++; $display("FAIL reset write_data got %h exp 0000", write_data); end
      checks++; if (write_tag_array !== 1'b0) begin errors++; $display("FAIL reset write_tag_array got %b exp 0", write_tag_array); end
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset fill_done got %b exp 0", fill_done); end
      step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      checks++; if (fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_release fsm_busy got %b exp 0", fsm_busy); end
   endtask

   // One fill scenario. vmask bit c = memory returns a word in cycle c.
   // Reads are expected in cycles 1..8 at exp_base+2*(c-1); fill_done only in
   // done_cyc. start_c=1 continues a fill whose miss cycle was already driven.
   // stray: miss held high (at another address) throughout the fill.
   // chain: a new miss at next_addr is presented in cycle done_cyc+1.
   task automatic test_fill(input string name, input logic [15:0] miss_addr,
                            input logic [15:0] exp_base, input logic [31:0] vmask,
                            input int done_cyc, input int start_c, input bit stray,
                            input bit chain, input logic [15:0] next_addr);
      int          exp_sel;
      int          dones;
      logic        vld;
      logic        miss;
      logic        exp_busy;
      logic        exp_en;
      logic        last;
      logic [15:0] addr;
      logic [15:0] data;
      exp_sel = 0;
      dones   = 0;
      for (int c = start_c; c <= done_cyc + 1; c++) begin
         vld  = vmask[c];
         miss = (c == 0) || (stray && (c <= done_cyc)) || (chain && (c == done_cyc + 1));
         if (c == 0) addr = miss_addr;
         else if (c == done_cyc + 1) addr = next_addr;
         else addr = 16'h5678;
         data = 16'hC300 ^ 16'(c * 273);
         step(1'b1, miss, addr, vld, data);
         last     = (c == done_cyc);
         exp_busy = (c <= done_cyc) || (chain && (c == done_cyc + 1));
         exp_en   = (c >= 1) && (c <= 8);
         checks++; if (fsm_busy !== exp_busy) begin errors++; $display("FAIL %s c%0d fsm_busy got %b exp %b", name, c, fsm_busy, exp_busy); end
         checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL %s c%0d mem_en got %b exp %b", name, c, mem_en, exp_en); end
         if (exp_en) begin
            checks++; if (memory_address !== exp_base + 16'(2 * (c - 1))) begin errors++; $display("FAIL %s c%0d memory_address got %h exp %h", name, c, memory_address, exp_base + 16'(2 * (c - 1))); end
         end
         checks++; if (write_data_array !== vld) begin errors++; $display("FAIL %s c%0d write_data_array got %b exp %b", name, c, write_data_array, vld); end
         if (vld) begin
            checks++; if (write_word_sel !== 3'(exp_sel)) begin errors++; $display("FAIL %s c%0d write_word_sel got %0d exp %0d", name, c, write_word_sel, exp_sel); end
            checks++; if (write_data !== data) begin errors++; $display("FAIL %s c%0d write_data got %h exp %h", name, c, write_data, data); end
            exp_sel++;
         end
         checks++; if (write_tag_array !== last) begin errors++; $display("FAIL %s c%0d write_tag_array got %b exp %b", name, c, write_tag_array, last); end
         checks++; if (fill_done !== last) begin errors++; $display("FAIL %s c%0d fill_done got %b exp %b", name, c, fill_done, last); end
         if (fill_done === 1'b1) dones++;
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL %s fill_done_count got %0d exp 1", name, dones); end
   endtask

   task automatic test_basic_fill();
      test_fill("basic", 16'h1236, 16'h1230, 32'h0000_1FE0, 12, 0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_top_of_memory();
      test_fill("top_mem", 16'hFFFE, 16'hFFF0, 32'h0000_1FE0, 12, 0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_back_to_back();
      test_fill("b2b_first", 16'h1236, 16'h1230, 32'h0000_1FE0, 12, 0, 1'b0, 1'b1, 16'h0040);
      test_fill("b2b_second", 16'h0040, 16'h0040, 32'h0000_1FE0, 12, 1, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_stray_inputs();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'h2222, 1'b1, 16'h1111);
         checks++; if (write_data_array !== 1'b0) begin errors++; $display("FAIL stray_idle i%0d write_data_array got %b exp 0", i, write_data_array); end
         checks++; if (fsm_busy !== 1'b0) begin errors++; $display("FAIL stray_idle i%0d fsm_busy got %b exp 0", i, fsm_busy); end
         checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL stray_idle i%0d mem_en got %b exp 0", i, mem_en); end
      end
      test_fill("stray_fill", 16'h1236, 16'h1230, 32'h0000_1FE0, 12, 0, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic test_reset_mid_fill();
      for (int c = 0; c <= 5; c++) begin
         step(1'b1, (c == 0), 16'h1236, (c == 5), 16'h7000);
      end
      step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7001);
      // Cycle 7: reset has taken effect, a late word arrives.
      step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h7002);
      checks++; if (fsm_busy !== 1'b0) begin errors++; $display("FAIL mid_reset fsm_busy got %b exp 0", fsm_busy); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_reset mem_en got %b exp 0", mem_en); end
      checks++; if (memory_address !== 16'h0000) begin errors++; $display("FAIL mid_reset memory_address got %h exp 0000", memory_address); end
      checks++; if (write_data_array !== 1'b0) begin errors++; $display("FAIL mid_reset write_data_array got %b exp 0", write_data_array); end
      checks++; if (write_data !== 16'h0000) begin errors++; $display("FAIL mid_reset write_data got %h exp 0000", write_data); end
      checks++; if (write_tag_array !== 1'b0) begin errors++; $display("FAIL mid_reset write_tag_array got %b exp 0", write_tag_array); end
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL mid_reset fill_done got %b exp 0", fill_done); end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'h0000, (i != 1), 16'h7100);
         checks++; if (write_data_array !== 1'b0) begin errors++; $display("FAIL mid_reset_late i%0d write_data_array got %b exp 0", i, write_data_array); end
         checks++; if (write_tag_array !== 1'b0) begin errors++; $display("FAIL mid_reset_late i%0d write_tag_array got %b exp 0", i, write_tag_array); end
      end
      test_fill("after_reset", 16'h0100, 16'h0100, 32'h0000_1FE0, 12, 0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_irregular_memory();
      // Words return in cycles 5,7,8,12,13,14,20,21.
      test_fill("irregular", 16'h2A4C, 16'h2A40, 32'h0030_71A0, 21, 0, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      rst_n             = 1'b0;
      miss_detected     = 1'b0;
      miss_address      = 16'h0000;
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
      test_reset();
      test_basic_fill();
      test_top_of_memory();
      test_back_to_back();
      test_stray_inputs();
      test_reset_mid_fill();
      test_irregular_memory();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
